// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder
//   Measures a servo PWM pulse stream in mclk ticks, checks the rise-to-rise
//   period and the high time of every frame, and decodes each good frame
//   into a pulse width, an 8-bit position (width/10) and a status word.
//
// Ports:
//   mclk        in   1   1 MHz clock, rising-edge logic
//   rst         in   1   asynchronous active-high reset
//   pwm_in      in   1   asynchronous servo pulse input
//   width       out  12  last good pulse width in ticks
//   position    out  8   floor(width/10)
//   status_word out  16  {2'b01, 2'b00, pos[7:4], 2'b00, pos[3:0], dir, hold}
//   frame_valid out  1   one-cycle pulse when the data outputs update
//   err_period  out  1   one-cycle pulse on period violation or timeout
//   err_width   out  1   one-cycle pulse on width violation
//   locked      out  1   rise seen and no timeout since
module servo_pulse_decoder #(
    parameter int PERIOD_MIN = 19000,
    parameter int PERIOD_MAX = 21000,
    parameter int WIDTH_MAX  = 2200
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [11:0] width,
    output logic [7:0]  position,
    output logic [15:0] status_word,
    output logic        frame_valid,
    output logic        err_period,
    output logic        err_width,
    output logic        locked
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t      state, state_next;
    logic        sync_p0, sync_p1, sync_p2;
    logic        rise, fall, timeout;
    logic        start, close, restart, count_en, high_en;
    logic [14:0] period_cnt;
    logic [11:0] width_cnt;
    logic [3:0]  sub_cnt;
    logic [7:0]  pos_cnt;
    logic        vld_p3;
    logic [14:0] period_p3;
    logic [11:0] width_p3;
    logic [7:0]  pos_p3;
    logic        dir, hold, dir_next, hold_next;
    logic        period_bad, width_bad;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] pack_status(input logic [7:0] p, input logic d, input logic h);
        return {2'b01, 2'b00, p[7:4], 2'b00, p[3:0], d, h};
    endfunction

    // Stage p0..p2: two-flop synchronizer plus one delay flop for edges
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= pwm_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise    = sync_p1 & ~sync_p2;
    assign fall    = ~sync_p1 & sync_p2;
    // Timeout wins over a rise arriving on the same cycle.
    assign timeout = (state != IDLE) && (period_cnt == 15'(PERIOD_MAX + 1));

    // FSM: state register
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rise) state_next = HIGH;
            HIGH: begin
                if (timeout)   state_next = IDLE;
                else if (rise) state_next = HIGH;
                else if (fall) state_next = LOW;
            end
            LOW: begin
                if (timeout)   state_next = IDLE;
                else if (rise) state_next = HIGH;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: decoded controls
    always_comb begin
        start    = (state == IDLE) && rise;
        close    = (state != IDLE) && !timeout && rise;
        restart  = start || close;
        count_en = (state != IDLE);
        high_en  = (state == HIGH);
    end

    // Stage p3: counters, and capture of the closed frame's measurements.
    // period_cnt restarts at 1 so that it equals the rise-to-rise distance
    // on the cycle the next rise is seen.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            period_cnt <= 15'd0;
            width_cnt  <= 12'd0;
            sub_cnt    <= 4'd0;
            pos_cnt    <= 8'd0;
            vld_p3     <= 1'b0;
            period_p3  <= 15'd0;
            width_p3   <= 12'd0;
            pos_p3     <= 8'd0;
        end else begin
            vld_p3 <= close;
            if (close) begin
                period_p3 <= period_cnt;
                width_p3  <= width_cnt;
                pos_p3    <= pos_cnt;
            end
            if (restart) begin
                period_cnt <= 15'd1;
                width_cnt  <= 12'd0;
                sub_cnt    <= 4'd0;
                pos_cnt    <= 8'd0;
            end else if (count_en) begin
                period_cnt <= period_cnt + 15'd1;
                if (high_en) begin
                    width_cnt <= sat_inc12(width_cnt);
                    // Mod-10 prescaler gives position without a divider.
                    if (sub_cnt == 4'd9) begin
                        sub_cnt <= 4'd0;
                        pos_cnt <= sat_inc8(pos_cnt);
                    end else begin
                        sub_cnt <= sub_cnt + 4'd1;
                    end
                end
            end
        end
    end

    assign period_bad = (period_p3 < 15'(PERIOD_MIN)) || (period_p3 > 15'(PERIOD_MAX));
    assign width_bad  = (width_p3 > 12'(WIDTH_MAX));

    // width only changes on good frames, so it is the previous good width.
    always_comb begin
        dir_next  = dir;
        hold_next = 1'b0;
        if (width_p3 > width)      dir_next = 1'b1;
        else if (width_p3 < width) dir_next = 1'b0;
        else                       hold_next = 1'b1;
    end

    // Stage p4: frame evaluation and output registers
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            width       <= 12'd0;
            position    <= 8'd0;
            status_word <= 16'h4000;
            dir         <= 1'b0;
            hold        <= 1'b0;
            frame_valid <= 1'b0;
            err_period  <= 1'b0;
            err_width   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            err_period  <= 1'b0;
            err_width   <= 1'b0;
            if (start)   locked <= 1'b1;
            if (timeout) begin
                locked     <= 1'b0;
                err_period <= 1'b1;
            end
            if (vld_p3) begin
                if (period_bad) begin
                    err_period <= 1'b1;
                end else if (width_bad) begin
                    err_width <= 1'b1;
                end else begin
                    frame_valid <= 1'b1;
                    width       <= width_p3;
                    position    <= pos_p3;
                    dir         <= dir_next;
                    hold        <= hold_next;
                    status_word <= pack_status(pos_p3, dir_next, hold_next);
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb_servo_pulse_decoder
//   Directed bench for servo_pulse_decoder. The period window is scaled down
//   (2400..2600 ticks, nominal 2500) to keep run time short; pulse widths
//   and expected decode values are the real ones.
`timescale 1ns/1ps
module tb_servo_pulse_decoder;

    localparam int PMIN = 2400;
    localparam int PMAX = 2600;
    localparam int WMAX = 2200;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic        pwm_in = 1'b0;
    logic [11:0] width;
    logic [7:0]  position;
    logic [15:0] status_word;
    logic        frame_valid, err_period, err_width, locked;

    servo_pulse_decoder #(
        .PERIOD_MIN(PMIN),
        .PERIOD_MAX(PMAX),
        .WIDTH_MAX (WMAX)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .width      (width),
        .position   (position),
        .status_word(status_word),
        .frame_valid(frame_valid),
        .err_period (err_period),
        .err_width  (err_width),
        .locked     (locked)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    // Pulse counters and the posedge index at which each pulse was seen.
    int fv_n = 0, ep_n = 0, ew_n = 0;
    int fv_edge = 0, ep_edge = 0, ew_edge = 0;
    always @(negedge mclk) begin
        if (frame_valid) begin fv_n <= fv_n + 1; fv_edge <= cyc; end
        if (err_period)  begin ep_n <= ep_n + 1; ep_edge <= cyc; end
        if (err_width)   begin ew_n <= ew_n + 1; ew_edge <= cyc; end
    end

    int n_tests = 0, n_fail = 0;
    int fv0, ep0, ew0;
    int rise_edge = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        fv0 = fv_n;
        ep0 = ep_n;
        ew0 = ew_n;
    endtask

    // Called on a negedge; drives pwm_in high for w sampling edges.
    task automatic hi(input int w);
        pwm_in    = 1'b1;
        rise_edge = cyc + 1;
        repeat (w) @(negedge mclk);
        pwm_in = 1'b0;
    endtask

    task automatic lo(input int n);
        repeat (n) @(negedge mclk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge mclk);
        check("rst_width", 32'(width), 32'd0);
        check("rst_pos", 32'(position), 32'd0);
        check("rst_sw", 32'(status_word), 32'h4000);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_flags", {29'd0, frame_valid, err_period, err_width}, 32'd0);
        rst = 1'b0;
        lo(5);

        // Basic decode: first rise starts, second closes a 1500/2500 frame
        snap(); hi(1500);
        check("r1_locked", 32'(locked), 32'd1);
        check("r1_fv", fv_n - fv0, 0);
        lo(1000);
        snap(); hi(1500);
        check("r2_fv", fv_n - fv0, 1);
        check("r2_fv_lat", fv_edge - rise_edge, 3);
        check("r2_width", 32'(width), 32'd1500);
        check("r2_pos", 32'(position), 32'd150);
        check("r2_sw", 32'(status_word), 32'h491A);
        check("r2_locked", 32'(locked), 32'd1);
        lo(1000);

        // Hold then direction change
        snap(); hi(1495);
        check("r3_fv", fv_n - fv0, 1);
        check("r3_sw_hold", 32'(status_word), 32'h491B);
        lo(1005);
        snap(); hi(2300);
        check("r4_fv", fv_n - fv0, 1);
        check("r4_pos", 32'(position), 32'd149);
        check("r4_sw", 32'(status_word), 32'h4914);
        lo(200);

        // Width error (2300) then a 1000-tick frame
        snap(); hi(1000);
        check("r5_ew", ew_n - ew0, 1);
        check("r5_ew_lat", ew_edge - rise_edge, 3);
        check("r5_fv", fv_n - fv0, 0);
        check("r5_ep", ep_n - ep0, 0);
        check("r5_width_held", 32'(width), 32'd1495);
        check("r5_sw_held", 32'(status_word), 32'h4914);
        lo(1500);
        snap(); hi(1500);
        check("r6_fv", fv_n - fv0, 1);
        check("r6_pos", 32'(position), 32'd100);
        check("r6_sw", 32'(status_word), 32'h4610);
        lo(500);

        // Short period (2000)
        snap(); hi(1500);
        check("r7_ep", ep_n - ep0, 1);
        check("r7_ep_lat", ep_edge - rise_edge, 3);
        check("r7_fv", fv_n - fv0, 0);
        check("r7_sw_held", 32'(status_word), 32'h4610);

        // Stuck low after the rise: timeout
        snap(); lo(1200);
        check("to_ep", ep_n - ep0, 1);
        check("to_lat", ep_edge - rise_edge, PMAX + 3);
        check("to_locked", 32'(locked), 32'd0);
        check("to_fv", fv_n - fv0, 0);
        check("to_sw_held", 32'(status_word), 32'h4610);

        // Relock: first rise locks, second decodes
        snap(); hi(1500);
        check("r8_locked", 32'(locked), 32'd1);
        check("r8_fv", fv_n - fv0, 0);
        check("r8_ep", ep_n - ep0, 0);
        lo(1000);
        snap(); hi(1500);
        check("r9_fv", fv_n - fv0, 1);
        check("r9_sw", 32'(status_word), 32'h491A);
        lo(1000);

        // Reset 700 ticks into a pulse
        snap(); hi(700);
        check("r10_fv", fv_n - fv0, 1);
        check("r10_sw_hold", 32'(status_word), 32'h491B);
        rst    = 1'b1;
        pwm_in = 1'b0;
        #1;
        check("mrst_width", 32'(width), 32'd0);
        check("mrst_pos", 32'(position), 32'd0);
        check("mrst_sw", 32'(status_word), 32'h4000);
        check("mrst_locked", 32'(locked), 32'd0);
        @(negedge mclk);
        lo(3);
        rst = 1'b0;
        lo(10);
        snap(); hi(1500);
        check("pr1_fv", fv_n - fv0, 0);
        check("pr1_locked", 32'(locked), 32'd1);
        lo(1000);
        snap(); hi(2200);
        check("pr2_fv", fv_n - fv0, 1);
        check("pr2_width", 32'(width), 32'd1500);
        check("pr2_sw", 32'(status_word), 32'h491A);
        lo(200);

        // Boundaries: period PMIN and PMAX with width WMAX, widths 9 and 10
        snap(); hi(2200);
        check("pmin_fv", fv_n - fv0, 1);
        check("pmin_width", 32'(width), 32'd2200);
        check("pmin_pos", 32'(position), 32'd220);
        check("pmin_sw", 32'(status_word), 32'h4D32);
        lo(400);
        snap(); hi(9);
        check("pmax_fv", fv_n - fv0, 1);
        check("pmax_ep", ep_n - ep0, 0);
        check("pmax_pos", 32'(position), 32'd220);
        check("pmax_sw", 32'(status_word), 32'h4D33);
        lo(2491);
        snap(); hi(10);
        check("w9_fv", fv_n - fv0, 1);
        check("w9_width", 32'(width), 32'd9);
        check("w9_pos", 32'(position), 32'd0);
        check("w9_sw", 32'(status_word), 32'h4000);
        lo(2490);
        snap(); hi(1500);
        check("w10_fv", fv_n - fv0, 1);
        check("w10_width", 32'(width), 32'd10);
        check("w10_pos", 32'(position), 32'd1);
        check("w10_sw", 32'(status_word), 32'h4006);
        lo(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
